// File: rtl/hex_pkg.sv
// Shared segment-code constants and the active-low segment vector type for the hex scan driver.
// Segment bit order is g..a (bit6=g, bit0=a); a 0 bit lights that segment.
package hex_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low seven-segment pattern; purely combinational, no state, no flow control.
module hex_seg_decode
  import hex_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex display scanner: staged value is swapped in only at frame boundaries; seg/dig_sel are
// registered (one cycle after index/shadow). No backpressure. Optional leading-zero blanking via HEX_LZ_BLANK_EN.
module hex_scan_driver
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    pending
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      staging_q, staging_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic       tick;
  logic       boundary;
  logic [3:0] nib;
  logic [6:0] dec_seg;

  always_comb begin
    tick     = (cnt_q == CNT_W'(PRESCALE - 1));
    boundary = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end

    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // A load landing on the boundary bypasses staging so the new frame starts with it.
    if (load) begin
      staging_d = value;
      pending_d = !boundary;
      if (boundary) begin
        shadow_d = value;
      end
    end else if (boundary && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    nib       = '0;
    dig_sel_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib          = shadow_q[4*i +: 4];
        dig_sel_d[i] = 1'b0;
      end
    end
  end

  hex_seg_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

`ifdef HEX_LZ_BLANK_EN
  logic lz_blank;
  logic upper_zero;

  // Walk from the top nibble down; a digit blanks while every nibble at or above it is zero.
  always_comb begin
    lz_blank   = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (shadow_q[4*i +: 4] == 4'h0);
      if ((idx_q == IDX_W'(i)) && upper_zero) begin
        lz_blank = 1'b1;
      end
    end
    seg_d = lz_blank ? SEG_BLANK : dec_seg;
  end
`else
  always_comb begin
    seg_d = dec_seg;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_sel_q <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench for hex_scan_driver (NUM_DIGITS=4, PRESCALE=3): a cycle-count reference model pushes
// the expected outputs after every clock edge and a negedge monitor pops and compares them.
module tb_hex_scan_driver;

  localparam int N = 4;
  localparam int P = 3;
  localparam int FRAME = N * P;

  logic          clock;
  logic          reset;
  logic [15:0]   value;
  logic          load;
  logic [6:0]    seg;
  logic [N-1:0]  dig_sel;
  logic          pending;

  hex_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clock   (clock),
    .reset   (reset),
    .value   (value),
    .load    (load),
    .seg     (seg),
    .dig_sel (dig_sel),
    .pending (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] dig;
    logic         pend;
    int           tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: cycles since reset release, plus staged/shown value.
  int          m_cyc = 0;
  logic [15:0] m_stage = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pend = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [15:0] sh, input int d);
    logic [15:0] upper;
    upper = sh >> (4 * d);
`ifdef HEX_LZ_BLANK_EN
    if (d > 0 && upper == 16'h0) return 7'b1111111;
`endif
    return seg_tbl[upper[3:0]];
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic [15:0] v);
    exp_t e;
    int   d;
    bit   bnd;
    edge_no++;
    e.tag = edge_no;
    if (r) begin
      m_cyc = 0; m_stage = '0; m_shadow = '0; m_pend = 1'b0;
      e.seg = 7'b1111111;
      e.dig = '1;
    end else begin
      d     = (m_cyc / P) % N;
      e.seg = ref_seg(m_shadow, d);
      e.dig = ~(N'(1) << d);
      bnd   = (m_cyc % FRAME) == FRAME - 1;
      if (l && bnd) begin
        m_shadow = v; m_stage = v; m_pend = 1'b0;
      end else if (l) begin
        m_stage = v; m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_shadow = m_stage; m_pend = 1'b0;
      end
      m_cyc++;
    end
    e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] v);
    reset = r; load = l; value = v;
    @(posedge clock);
    #1;
    model_edge(r, l, v);
  endtask

  task automatic idle_until(input int phase);
    for (int k = 0; k < FRAME && (m_cyc % FRAME) != phase; k++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL seg edge=%0d got=%b exp=%b", e.tag, seg, e.seg);
        end
        if (dig_sel !== e.dig) begin
          errors++;
          $display("FAIL dig_sel edge=%0d got=%b exp=%b", e.tag, dig_sel, e.dig);
        end
        if (pending !== e.pend) begin
          errors++;
          $display("FAIL pending edge=%0d got=%b exp=%b", e.tag, pending, e.pend);
        end
      end
    end
  end

  initial begin : stim
    logic        r, l;
    logic [15:0] v;
    reset = 1'b1; load = 1'b0; value = '0;
    repeat (3) step(1'b1, 1'b0, 16'h0);

    // Power-up scan of zero, then 12AF loaded and shown over two frames.
    step(1'b0, 1'b1, 16'h12AF);
    repeat (2 * FRAME + 2) step(1'b0, 1'b0, 16'h0);

    // Mid-frame double load: only the later value reaches the display.
    idle_until(4);
    step(1'b0, 1'b1, 16'h1111);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h2222);
    repeat (FRAME + 4) step(1'b0, 1'b0, 16'h0);

    // Load exactly on the boundary tick.
    idle_until(FRAME - 1);
    step(1'b0, 1'b1, 16'h3C5E);
    repeat (FRAME + 2) step(1'b0, 1'b0, 16'h0);

    // Leading-zero patterns.
    foreach (seg_tbl[k]) begin
      if (k < 3) begin
        idle_until(0);
        step(1'b0, 1'b1, (k == 0) ? 16'h0005 : (k == 1) ? 16'h0000 : 16'h0100);
        repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0);
      end
    end

    // Reset at digit 2 with a staged value waiting.
    idle_until(2 * P);
    step(1'b0, 1'b1, 16'hBEEF);
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    repeat (FRAME + 2) step(1'b0, 1'b0, 16'h0);

    // Random traffic with occasional resets and small values.
    for (int t = 0; t < 800; t++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 6) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v >> (4 * $urandom_range(1, 3));
      step(r, l, v);
    end

    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter NUM_DIGITS, default 4: number of hex digits driven; legal range 1..8.
REQ-003 Parameter PRESCALE, default 50000: clock cycles each digit is shown; legal range >= 1.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 value  input  4*NUM_DIGITS  hex value to display; nibble i drives digit i, and digit 0 is least significant.
REQ-007 load  input  1  single-cycle strobe that stages value for display.
REQ-008 seg  output  7  active-low segments, bit0=a .. bit6=g.
REQ-009 dig_sel  output  NUM_DIGITS  active-low digit enable, one-hot-low when active.
REQ-010 pending  output  1  high while a staged value awaits the frame boundary.

Function
REQ-011 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be asserted in the cycle the count equals PRESCALE-1 (every cycle when PRESCALE=1).
REQ-012 Digit index SHALL advance on each tick: 0,1,..,NUM_DIGITS-1, then 0.
REQ-013 Frame boundary SHALL be the tick on which the index wraps from NUM_DIGITS-1 to 0.
REQ-014 On load, value SHALL be captured into the staging register and pending set the next cycle; a later load before the boundary SHALL overwrite the staged value.
REQ-015 At the frame boundary with pending=1, the staged value SHALL be copied to the shadow register and pending cleared.
REQ-016 If load coincides with the frame boundary, the shadow register SHALL take value directly and pending SHALL end at 0.
REQ-017 seg and dig_sel SHALL be registered outputs: one cycle after the index or shadow changes, dig_sel SHALL equal ~(1<<index) and seg SHALL be the decode of shadow nibble index.
REQ-018 Decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (written g..a); blank SHALL be 1111111.
REQ-019 A displayed value SHALL never change partway through a frame.

Reset
REQ-020 While reset is high: prescaler=0, index=0, staging=0, shadow=0, pending=0, seg=1111111, dig_sel all ones.
REQ-021 In the first cycle after reset deasserts, dig_sel SHALL equal ~1 and seg SHALL show 1000000.
REQ-022 Reset asserted mid-frame SHALL discard any staged value and restart the scan at digit 0.

Configuration
REQ-023 With macro HEX_LZ_BLANK_EN defined, digit i>0 SHALL be blanked when nibble i and all higher nibbles of shadow are 0; digit 0 SHALL never be blanked.
REQ-024 Without HEX_LZ_BLANK_EN, every digit SHALL display its nibble and no blanking logic SHALL exist.

Structure
REQ-025 Package hex_pkg SHALL hold the 16 segment constants, the SEG_BLANK constant and the segment-vector typedef.
REQ-026 Combinational sub-module hex_seg_decode (4-bit in, 7-bit active-low out) SHALL perform the decode; hex_scan_driver SHALL instantiate it once.

Verification
REQ-027 NUM_DIGITS=4, PRESCALE=3, reset, then value=16'h12AF with load -> after the first boundary, the scan shows F,A,2,1 on dig_sel 1110,1101,1011,0111, each for 3 cycles.
REQ-028 Load at mid-frame -> pending=1 until the boundary; the shadow is unchanged for the remainder of the frame; pending=0 the cycle after the boundary.
REQ-029 Two loads within one frame (16'h1111, then 16'h2222) -> the next frame shows 2222 only.
REQ-030 Load coincident with the boundary tick -> the new value shows from digit 0 of that frame, and pending stays 0.
REQ-031 HEX_LZ_BLANK_EN defined, value=16'h0005 -> digits 3..1 show 1111111 and digit 0 shows 0010010; value=16'h0000 -> digit 0 shows 1000000.
REQ-032 Reset asserted at index 2 with pending=1 -> outputs are off during reset; after release the block shows digit 0 = 0 and pending=0.
